// File: rtl/issue_scheduler_if.sv
// Decoder, execution-unit and writeback signals of the issue scheduler.
// The master side is the surrounding pipeline and the slave side is the scheduler.
interface issue_scheduler_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [1:0]  dec_unit;
  logic        dec_fence;
  logic [4:0]  dec_rd;
  logic        dec_rd_fp;
  logic        dec_rd_we;
  logic [14:0] dec_rs;
  logic [2:0]  dec_rs_en;
  logic [2:0]  dec_rs_fp;
  logic        alu_busy;
  logic        mem_busy;
  logic        fpu_busy;
  logic [2:0]  wb_valid;
  logic [14:0] wb_rd;
  logic [2:0]  wb_fp;
  logic        alu_issue;
  logic        mem_issue;
  logic        fpu_issue;
  logic [4:0]  iss_rd;
  logic        iss_rd_fp;
  logic        bad_inst;
  logic [3:0]  inflight;
  logic        draining;

  modport master (
    output dec_valid, dec_unit, dec_fence, dec_rd, dec_rd_fp, dec_rd_we,
    output dec_rs, dec_rs_en, dec_rs_fp, alu_busy, mem_busy, fpu_busy,
    output wb_valid, wb_rd, wb_fp,
    input  dec_ready, alu_issue, mem_issue, fpu_issue, iss_rd, iss_rd_fp,
    input  bad_inst, inflight, draining
  );

  modport slave (
    input  dec_valid, dec_unit, dec_fence, dec_rd, dec_rd_fp, dec_rd_we,
    input  dec_rs, dec_rs_en, dec_rs_fp, alu_busy, mem_busy, fpu_busy,
    input  wb_valid, wb_rd, wb_fp,
    output dec_ready, alu_issue, mem_issue, fpu_issue, iss_rd, iss_rd_fp,
    output bad_inst, inflight, draining
  );
endinterface

// File: rtl/issue_scheduler.sv
// Single-issue dispatch controller: hazard checks against a 64-entry register
// scoreboard, registered one-cycle issue pulses and fence draining.
module issue_scheduler #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input logic              clk,
  input logic              n_rst,
  issue_scheduler_if.slave bus
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [63:0] sb_q, sb_d, sb_byp, clr_mask, set_mask;
  logic [3:0]  inflight_q, inflight_d, inflight_byp, clr_cnt;
  logic        raw, waw, strct, unit_busy, any_busy, rd_x0, legal;
  logic        ready, hs, issue_hs, set_en;
  logic [5:0]  rd_idx;
  logic        alu_q, mem_q, fpu_q, bad_q, iss_rd_fp_q;
  logic [4:0]  iss_rd_q;

  // Writeback clears are applied before hazard checks so a dependent can go the same cycle.
  always_comb begin
    clr_mask = '0;
    for (int u = 0; u < 3; u++) begin
      if (bus.wb_valid[u]) clr_mask[{bus.wb_fp[u], bus.wb_rd[u*5 +: 5]}] = 1'b1;
    end
    sb_byp  = sb_q & ~clr_mask;
    clr_cnt = '0;
    for (int b = 0; b < 64; b++) clr_cnt = clr_cnt + 4'(sb_q[b] & clr_mask[b]);
    inflight_byp = inflight_q - clr_cnt;
  end

  always_comb begin
    raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raw = raw | (bus.dec_rs_en[i] & sb_byp[{bus.dec_rs_fp[i], bus.dec_rs[i*5 +: 5]}]);
    end
    rd_idx = {bus.dec_rd_fp, bus.dec_rd};
    rd_x0  = !bus.dec_rd_fp && (bus.dec_rd == 5'd0);
    waw    = bus.dec_rd_we & sb_byp[rd_idx];
    unique case (bus.dec_unit)
      2'b00:   unit_busy = bus.alu_busy;
      2'b01:   unit_busy = bus.mem_busy;
      2'b10:   unit_busy = bus.fpu_busy;
      default: unit_busy = 1'b0;
    endcase
    any_busy = bus.alu_busy | bus.mem_busy | bus.fpu_busy;
    strct    = unit_busy | (bus.dec_rd_we & (inflight_byp == 4'(MAX_INFLIGHT)));
    legal    = bus.dec_unit != 2'b11;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    if (state_q == RUN) begin
      if (bus.dec_valid) begin
        if (bus.dec_fence) begin
          if (inflight_q != 4'd0 || any_busy) state_d = DRAIN;
          else                                ready   = 1'b1;
        end else if (!legal) begin
          ready = 1'b1;
        end else begin
          ready = !raw && !waw && !strct;
        end
      end
    end else if (inflight_q == 4'd0 && !any_busy) begin
      // The held fence retires on the cycle the machine is found idle.
      state_d = RUN;
      ready   = bus.dec_valid;
    end
    if (!n_rst) ready = 1'b0;
  end

  always_comb begin
    hs         = bus.dec_valid & ready;
    issue_hs   = hs & !bus.dec_fence & legal;
    set_en     = issue_hs & bus.dec_rd_we & !rd_x0;
    set_mask   = 64'(set_en) << rd_idx;
    sb_d       = sb_byp | set_mask;
    inflight_d = inflight_byp + 4'(set_en);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= RUN;
      sb_q        <= '0;
      inflight_q  <= '0;
      alu_q       <= 1'b0;
      mem_q       <= 1'b0;
      fpu_q       <= 1'b0;
      bad_q       <= 1'b0;
      iss_rd_q    <= '0;
      iss_rd_fp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sb_q       <= sb_d;
      inflight_q <= inflight_d;
      alu_q      <= issue_hs & (bus.dec_unit == 2'b00);
      mem_q      <= issue_hs & (bus.dec_unit == 2'b01);
      fpu_q      <= issue_hs & (bus.dec_unit == 2'b10);
      bad_q      <= hs & !bus.dec_fence & !legal;
      if (issue_hs) begin
        iss_rd_q    <= bus.dec_rd;
        iss_rd_fp_q <= bus.dec_rd_fp;
      end
    end
  end

  assign bus.dec_ready = ready;
  assign bus.alu_issue = alu_q;
  assign bus.mem_issue = mem_q;
  assign bus.fpu_issue = fpu_q;
  assign bus.bad_inst  = bad_q;
  assign bus.iss_rd    = iss_rd_q;
  assign bus.iss_rd_fp = iss_rd_fp_q;
  assign bus.inflight  = inflight_q;
  assign bus.draining  = state_q == DRAIN;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: stimulus pushes expected issue pulses into a
// queue that a negedge monitor pops whenever an issue or bad_inst pulse appears.
module tb_issue_scheduler;
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  issue_scheduler_if bus_if ();
  issue_scheduler #(.MAX_INFLIGHT(4)) dut (.clk(clk), .n_rst(n_rst), .bus(bus_if));

  typedef struct packed {
    logic [3:0] pulses;  // {bad, fpu, mem, alu}
    logic [4:0] rd;
    logic       fp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [1:0] unit, input logic fence, input logic [4:0] rd,
                          input logic rd_fp, input logic we, input logic [14:0] rs,
                          input logic [2:0] en, input logic [2:0] rsfp);
    bus_if.dec_unit  = unit;
    bus_if.dec_fence = fence;
    bus_if.dec_rd    = rd;
    bus_if.dec_rd_fp = rd_fp;
    bus_if.dec_rd_we = we;
    bus_if.dec_rs    = rs;
    bus_if.dec_rs_en = en;
    bus_if.dec_rs_fp = rsfp;
    bus_if.dec_valid = 1'b1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.pulses = 4'b0001 << bus_if.dec_unit;
    e.rd     = bus_if.dec_rd;
    e.fp     = bus_if.dec_rd_fp;
    exp_q.push_back(e);
  endtask

  task automatic wb(input logic [2:0] v, input logic [14:0] rd, input logic [2:0] fp);
    bus_if.wb_valid = v;
    bus_if.wb_rd    = rd;
    bus_if.wb_fp    = fp;
  endtask

  task automatic expect_ready(input string name, input logic val);
    @(negedge clk);
    check(name, bus_if.dec_ready, val);
  endtask

  // Hold the instruction until it hand-shakes or the cycle budget runs out.
  task automatic send(input string name, input logic [1:0] unit, input logic fence,
                      input logic [4:0] rd, input logic rd_fp, input logic we,
                      input logic [14:0] rs, input logic [2:0] en, input logic [2:0] rsfp,
                      input int budget);
    logic hs;
    hs = 1'b0;
    set_inst(unit, fence, rd, rd_fp, we, rs, en, rsfp);
    for (int c = 0; c < budget && !hs; c++) begin
      @(negedge clk);
      if (bus_if.dec_ready) begin
        hs = 1'b1;
        if (!fence) push_exp();
      end
      tick();
    end
    bus_if.dec_valid = 1'b0;
    check(name, hs, 1'b1);
  endtask

  always @(negedge clk) begin
    logic [3:0] pulses;
    exp_t       e;
    pulses = {bus_if.bad_inst, bus_if.fpu_issue, bus_if.mem_issue, bus_if.alu_issue};
    if (pulses != 4'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", pulses, 4'b0);
      end else begin
        e = exp_q.pop_front();
        check("issue_kind", pulses, e.pulses);
        if (!e.pulses[3]) begin
          check("iss_rd", bus_if.iss_rd, e.rd);
          check("iss_rd_fp", bus_if.iss_rd_fp, e.fp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_rst = 1'b0;
    bus_if.alu_busy = 1'b0;
    bus_if.mem_busy = 1'b0;
    bus_if.fpu_busy = 1'b0;
    wb(3'b0, 15'd0, 3'b0);
    set_inst(2'b00, 1'b0, 5'd1, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0);
    @(negedge clk);
    check("rst_ready", bus_if.dec_ready, 1'b0);
    check("rst_inflight", bus_if.inflight, 4'd0);
    check("rst_draining", bus_if.draining, 1'b0);
    check("rst_iss_rd", bus_if.iss_rd, 5'd0);
    bus_if.dec_valid = 1'b0;
    tick();
    n_rst = 1'b1;

    // Independent ALU writes on consecutive cycles.
    send("alu_x1", 2'b00, 1'b0, 5'd1, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("inflight_1", bus_if.inflight, 4'd1);
    send("alu_x2", 2'b00, 1'b0, 5'd2, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("inflight_2", bus_if.inflight, 4'd2);
    send("alu_x3", 2'b00, 1'b0, 5'd3, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("inflight_3", bus_if.inflight, 4'd3);
    wb(3'b111, {5'd3, 5'd2, 5'd1}, 3'b000);
    tick();
    wb(3'b0, 15'd0, 3'b0);
    check("inflight_clr3", bus_if.inflight, 4'd0);

    // RAW stall released by a same-cycle writeback.
    send("add_x5", 2'b00, 1'b0, 5'd5, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    set_inst(2'b00, 1'b0, 5'd6, 1'b0, 1'b1, {5'd0, 5'd7, 5'd5}, 3'b011, 3'b000);
    expect_ready("raw_stall0", 1'b0);
    tick();
    expect_ready("raw_stall1", 1'b0);
    tick();
    wb(3'b001, {10'd0, 5'd5}, 3'b000);
    expect_ready("raw_bypass", 1'b1);
    push_exp();
    tick();
    bus_if.dec_valid = 1'b0;
    wb(3'b0, 15'd0, 3'b0);
    check("inflight_after_bypass", bus_if.inflight, 4'd1);
    wb(3'b001, {10'd0, 5'd6}, 3'b000);
    tick();
    wb(3'b0, 15'd0, 3'b0);
    check("inflight_x6_clr", bus_if.inflight, 4'd0);

    // x0 is never tracked; f0 is.
    send("alu_x0", 2'b00, 1'b0, 5'd0, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("x0_no_set", bus_if.inflight, 4'd0);
    send("fpu_f0", 2'b10, 1'b0, 5'd0, 1'b1, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("f0_set", bus_if.inflight, 4'd1);
    set_inst(2'b10, 1'b0, 5'd1, 1'b1, 1'b1, 15'd0, 3'b001, 3'b001);
    expect_ready("f0_raw", 1'b0);
    tick();
    bus_if.dec_valid = 1'b0;
    wb(3'b110, 15'd0, 3'b110);
    tick();
    wb(3'b0, 15'd0, 3'b0);
    check("dup_clear", bus_if.inflight, 4'd0);

    // Scoreboard-full structural hazard.
    for (int r = 1; r <= 4; r++)
      send("fill", 2'b00, 1'b0, 5'(r), 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("inflight_full", bus_if.inflight, 4'd4);
    set_inst(2'b00, 1'b0, 5'd8, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0);
    expect_ready("full_hold", 1'b0);
    tick();
    send("store", 2'b01, 1'b0, 5'd0, 1'b0, 1'b0, {5'd0, 5'd11, 5'd10}, 3'b011, 3'b0, 1);
    check("store_inflight", bus_if.inflight, 4'd4);
    set_inst(2'b00, 1'b0, 5'd8, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0);
    wb(3'b001, {10'd0, 5'd1}, 3'b000);
    expect_ready("full_bypass", 1'b1);
    push_exp();
    tick();
    bus_if.dec_valid = 1'b0;
    wb(3'b0, 15'd0, 3'b0);
    check("inflight_swap", bus_if.inflight, 4'd4);
    bus_if.mem_busy = 1'b1;
    set_inst(2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 15'd0, 3'b0, 3'b0);
    expect_ready("mem_busy", 1'b0);
    tick();
    bus_if.mem_busy  = 1'b0;
    bus_if.dec_valid = 1'b0;
    wb(3'b111, {5'd4, 5'd3, 5'd2}, 3'b000);
    tick();
    wb(3'b001, {10'd0, 5'd8}, 3'b000);
    tick();
    wb(3'b0, 15'd0, 3'b0);
    check("inflight_empty", bus_if.inflight, 4'd0);

    // Fence with two pending writes drains first.
    send("pre_fence_x1", 2'b00, 1'b0, 5'd1, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    send("pre_fence_x2", 2'b00, 1'b0, 5'd2, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    set_inst(2'b00, 1'b1, 5'd0, 1'b0, 1'b0, 15'd0, 3'b0, 3'b0);
    expect_ready("fence_hold", 1'b0);
    tick();
    check("drain_enter", bus_if.draining, 1'b1);
    wb(3'b001, {10'd0, 5'd1}, 3'b000);
    expect_ready("drain_ready1", 1'b0);
    tick();
    wb(3'b001, {10'd0, 5'd2}, 3'b000);
    expect_ready("drain_ready2", 1'b0);
    tick();
    wb(3'b0, 15'd0, 3'b0);
    check("drain_hold", bus_if.draining, 1'b1);
    send("fence_consume", 2'b00, 1'b1, 5'd0, 1'b0, 1'b0, 15'd0, 3'b0, 3'b0, 3);
    check("drain_exit", bus_if.draining, 1'b0);
    check("fence_inflight", bus_if.inflight, 4'd0);

    // Illegal unit: consumed, one-cycle bad_inst, no scoreboard effect.
    send("illegal", 2'b11, 1'b0, 5'd7, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("illegal_no_set", bus_if.inflight, 4'd0);
    tick();
    check("bad_one_cycle", bus_if.bad_inst, 1'b0);

    // Reset while draining.
    send("pre_rst_x1", 2'b00, 1'b0, 5'd1, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    set_inst(2'b00, 1'b1, 5'd0, 1'b0, 1'b0, 15'd0, 3'b0, 3'b0);
    tick();
    check("rst_drain_enter", bus_if.draining, 1'b1);
    n_rst = 1'b0;
    expect_ready("rst_mid_ready", 1'b0);
    tick();
    check("rst_mid_inflight", bus_if.inflight, 4'd0);
    check("rst_mid_draining", bus_if.draining, 1'b0);
    bus_if.dec_valid = 1'b0;
    n_rst = 1'b1;
    send("post_rst_x3", 2'b00, 1'b0, 5'd3, 1'b0, 1'b1, 15'd0, 3'b0, 3'b0, 1);
    check("post_rst_inflight", bus_if.inflight, 4'd1);

    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Single-issue dispatch controller between the RV32G instruction decoder and the ALU, MEM and FPU execution units. It accepts one decoded instruction per cycle over a valid/ready handshake. It holds the instruction back on register hazards, a busy target unit, a full scoreboard or a pending fence. It then issues the instruction to exactly one unit through a registered one-cycle pulse and tracks outstanding register writes in a 64-entry scoreboard (32 integer + 32 FP).

## Interface
- MAX_INFLIGHT, default 4: maximum pending register writes; range 1..15.
- clk  in  1  clock.
- n_rst  in  1  reset; synchronous, active-low; clock clk.
- dec_valid  in  1  decoded instruction present.
- dec_ready  out  1  instruction consumed this cycle. Combinational.
- dec_unit  in  2  target unit: 00 ALU, 01 MEM, 10 FPU, 11 illegal.
- dec_fence  in  1  instruction is a fence (FENCE/FENCE.I); no unit, no rd.
- dec_rd  in  5  destination register.
- dec_rd_fp  in  1  dec_rd is in the FP register file.
- dec_rd_we  in  1  instruction writes dec_rd.
- dec_rs  in  15  {rs3, rs2, rs1} source registers.
- dec_rs_en  in  3  per-source enable.
- dec_rs_fp  in  3  per-source FP-file flag.
- alu_busy, mem_busy, fpu_busy  in  1 each  unit cannot accept an instruction.
- wb_valid  in  3  per-unit writeback strobe {fpu, mem, alu}.
- wb_rd  in  15  per-unit writeback register {fpu, mem, alu}.
- wb_fp  in  3  per-unit writeback file flag.
- alu_issue, mem_issue, fpu_issue  out  1 each  registered issue pulse.
- iss_rd  out  5  registered dec_rd of the issued instruction.
- iss_rd_fp  out  1  registered dec_rd_fp of the issued instruction.
- bad_inst  out  1  registered pulse when an illegal instruction is consumed.
- inflight  out  4  number of scoreboard bits set.
- draining  out  1  FSM is in DRAIN.

## Operation
- Scoreboard index: {fp, reg}. Integer x0 is never set and never hazards. FP f0 is tracked like any other register.
- Same-cycle writeback clears are bypassed into the hazard check.
- RAW: any enabled source whose scoreboard bit is set after bypass.
- WAW: dec_rd_we and the dec_rd bit is set after bypass.
- Struct: the target unit's busy input is high, or dec_rd_we and inflight == MAX_INFLIGHT after bypass.
- FSM states:
  - RUN, the reset state.
  - DRAIN, entered when dec_valid & dec_fence arrives in RUN while inflight != 0 or any busy input is high. In DRAIN, dec_ready = 0.
  - DRAIN returns to RUN once inflight == 0 and all busy inputs are low. The fence is consumed that cycle; it produces no issue pulse.
  - A fence arriving when already idle is consumed in RUN in one cycle.
- RUN, non-fence instructions:
  - dec_ready = 1 if dec_unit == 11. Consumption sets bad_inst the next cycle; there is no issue and the scoreboard is unchanged.
  - Otherwise dec_ready = dec_valid & !RAW & !WAW & !struct.
- On a handshake with a legal unit, the selected issue pulse and iss_rd/iss_rd_fp assert the next cycle. If dec_rd_we and rd is not int x0, the scoreboard bit is set.
- Writeback: a valid wb clears its bit. A clear of a non-set bit is ignored. Duplicate clears of the same register in one cycle count once.
- Same-edge set and clear of the same register: set wins.
- inflight = popcount of the scoreboard, maintained as a counter: +1 on a set, −N for the distinct set bits cleared.

## Timing
- Reset: scoreboard cleared, FSM RUN, inflight 0. All issue pulses, bad_inst, draining, iss_rd and iss_rd_fp are 0. Combinational dec_ready is forced to 0 while n_rst = 0.
- Issue latency: handshake at edge N → pulse high for cycle N+1 only.
- Scoreboard effect: a set at edge N blocks dependents sampled from cycle N+1.
- Writeback clear: a wb at cycle M allows a dependent to hand-shake in cycle M (bypass).
- Back-to-back independent instructions sustain 1 per cycle.
- Reset mid-operation clears all state regardless of pending writebacks. The units are reset by the same n_rst.

## Test plan
- Independent ALU ops (rd x1, x2, x3) on consecutive cycles → alu_issue high for 3 consecutive cycles; inflight goes 1, 2, 3.
- Issue `add x5`, then `sub x6, x5, x7` → second instruction stalled (dec_ready 0) until wb_valid[0] with wb_rd = 5. It hand-shakes in that same cycle and alu_issue asserts the next cycle.
- Write to x0 → no scoreboard set, inflight stays 0. FP write to f0 → set, inflight 1.
- MAX_INFLIGHT = 4 with four pending writes → fifth writer held. A non-writing store (dec_rd_we 0, MEM) still issues.
- Fence with inflight 2 → draining = 1 the next cycle and dec_ready stays 0. After both writebacks clear and busy inputs are low, the fence is consumed with no issue pulse and draining returns to 0.
- dec_unit = 11 → consumed immediately, bad_inst pulse for one cycle, no issue. Assert n_rst mid-drain → inflight 0, FSM RUN the next cycle.
